// File: rtl/stopwatch_up.sv
// Count-up stopwatch, 000-999 s in three BCD digits, with run/pause, clear,
// lap hold, saturation at 999 and a one-cycle tick per counted second.
module stopwatch_up #(
   parameter int TICKS_PER_SEC = 50000000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       go,
   input  logic       clear,
   input  logic       lap,
   output logic [3:0] hundreds,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       running,
   output logic       full,
   output logic       tick
);

   localparam int DIV_W = ($clog2(TICKS_PER_SEC) < 1) ? 1 : $clog2(TICKS_PER_SEC);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICKS_PER_SEC - 1);
   localparam logic [11:0] CNT_MAX = 12'h999;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, FULL} state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [11:0]      cnt_q, cnt_d;
   logic [11:0]      lap_q, lap_d;
   logic             hold_q, hold_d;
   logic             tick_q, tick_d;
   logic [11:0]      cnt_inc;

   // Saturating three-digit BCD increment; each digit rolls 9 -> 0 into the next.
   function automatic logic [11:0] bcd_inc(input logic [11:0] v);
      logic [3:0] h, t, o;
      {h, t, o} = v;
      if (v == CNT_MAX) return v;
      if (o == 4'd9) begin
         o = 4'd0;
         if (t == 4'd9) begin
            t = 4'd0;
            h = h + 4'd1;
         end else begin
            t = t + 4'd1;
         end
      end else begin
         o = o + 4'd1;
      end
      return {h, t, o};
   endfunction

   assign cnt_inc = bcd_inc(cnt_q);

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      lap_d   = lap_q;
      hold_d  = hold_q;
      tick_d  = 1'b0;

      if (lap) begin
         if (!hold_q) begin
            lap_d  = cnt_q;
            hold_d = 1'b1;
         end else begin
            hold_d = 1'b0;
         end
      end

      unique case (state_q)
         IDLE:  if (go) state_d = RUN;
         PAUSE: if (go) state_d = RUN;
         RUN: begin
            // Dropping go freezes the divider so the partial second survives the pause.
            if (!go) begin
               state_d = PAUSE;
            end else if (div_q == DIV_MAX) begin
               div_d  = '0;
               cnt_d  = cnt_inc;
               tick_d = 1'b1;
               if (cnt_inc == CNT_MAX) state_d = FULL;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         FULL: ;
         default: state_d = IDLE;
      endcase

      if (clear) begin
         state_d = IDLE;
         div_d   = '0;
         cnt_d   = '0;
         lap_d   = '0;
         hold_d  = 1'b0;
         tick_d  = 1'b0;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q <= IDLE;
         div_q   <= '0;
         cnt_q   <= '0;
         lap_q   <= '0;
         hold_q  <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         lap_q   <= lap_d;
         hold_q  <= hold_d;
         tick_q  <= tick_d;
      end
   end

   assign {hundreds, tens, ones} = hold_q ? lap_q : cnt_q;
   assign running = (state_q == RUN);
   assign full    = (state_q == FULL);
   assign tick    = tick_q;

endmodule

// File: tb/tb_stopwatch_up.sv
// Directed bench for stopwatch_up (TICKS_PER_SEC=4): an integer-seconds model
// checked every cycle, plus hand-computed literal expectations.
module tb_stopwatch_up;

   localparam int T = 4;

   logic       clk = 1'b0;
   logic       reset, go, clear, lap;
   logic [3:0] hundreds, tens, ones;
   logic       running, full, tick;

   int checks = 0;
   int errors = 0;

   stopwatch_up #(.TICKS_PER_SEC(T)) dut (
      .CLOCK_50 (clk),
      .reset    (reset),
      .go       (go),
      .clear    (clear),
      .lap      (lap),
      .hundreds (hundreds),
      .tens     (tens),
      .ones     (ones),
      .running  (running),
      .full     (full),
      .tick     (tick)
   );

   always #5 clk = ~clk;

   // Model: elapsed whole seconds, cycles into the current second, run flag, lap.
   int m_secs = 0, m_phase = 0, m_lap = 0;
   bit m_run = 0, m_hold = 0, m_tick = 0, m_valid = 0;

   task automatic cmp(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   initial begin
      bit s_reset, s_go, s_clear, s_lap;
      int shown;
      forever begin
         @(posedge clk);
         s_reset = reset; s_go = go; s_clear = clear; s_lap = lap;
         if (s_reset) begin
            m_secs = 0; m_phase = 0; m_lap = 0;
            m_run = 0; m_hold = 0; m_tick = 0; m_valid = 1;
         end else begin
            if (s_lap) begin
               if (!m_hold) begin
                  m_lap  = m_secs;
                  m_hold = 1;
               end else begin
                  m_hold = 0;
               end
            end
            m_tick = 0;
            if (s_clear) begin
               m_secs = 0; m_phase = 0; m_hold = 0; m_run = 0;
            end else if (m_secs == 999) begin
               m_run = 0;
            end else if (!m_run) begin
               m_run = s_go;
            end else if (!s_go) begin
               m_run = 0;
            end else if (m_phase == T - 1) begin
               m_phase = 0;
               m_secs  = m_secs + 1;
               m_tick  = 1;
               if (m_secs == 999) m_run = 0;
            end else begin
               m_phase = m_phase + 1;
            end
         end
         @(negedge clk);
         if (m_valid) begin
            shown = m_hold ? m_lap : m_secs;
            cmp("model_hundreds", int'(hundreds), shown / 100);
            cmp("model_tens",     int'(tens),     (shown / 10) % 10);
            cmp("model_ones",     int'(ones),     shown % 10);
            cmp("model_running",  int'(running),  int'(m_run));
            cmp("model_full",     int'(full),     (m_secs == 999) ? 1 : 0);
            cmp("model_tick",     int'(tick),     int'(m_tick));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #2;
   endtask

   function automatic int bcd();
      return int'({hundreds, tens, ones});
   endfunction

   initial begin
      reset = 1'b1; go = 1'b0; clear = 1'b0; lap = 1'b0;
      step(2);
      cmp("reset_digits",  bcd(), 'h000);
      cmp("reset_running", int'(running), 0);
      cmp("reset_full",    int'(full), 0);
      cmp("reset_tick",    int'(tick), 0);
      reset = 1'b0;
      go    = 1'b1;

      step(1);
      cmp("start_running", int'(running), 1);
      cmp("start_digits",  bcd(), 'h000);
      step(4);
      cmp("first_inc", bcd(), 'h001);
      cmp("first_tick", int'(tick), 1);
      step(1);
      cmp("tick_single_cycle", int'(tick), 0);
      step(3);
      cmp("second_inc", bcd(), 'h002);
      cmp("second_tick", int'(tick), 1);

      step(2);
      go = 1'b0;
      step(1);
      cmp("pause_running", int'(running), 0);
      step(19);
      cmp("pause_hold", bcd(), 'h002);
      cmp("pause_tick", int'(tick), 0);
      go = 1'b1;
      step(1);
      cmp("resume_running", int'(running), 1);
      step(1);
      cmp("resume_not_yet", bcd(), 'h002);
      step(1);
      cmp("resume_inc", bcd(), 'h003);
      cmp("resume_tick", int'(tick), 1);

      step(8);
      cmp("live_005", bcd(), 'h005);
      lap = 1'b1;
      step(1);
      lap = 1'b0;
      cmp("lap_capture", bcd(), 'h005);
      step(15);
      cmp("lap_holding", bcd(), 'h005);
      lap = 1'b1;
      step(1);
      lap = 1'b0;
      cmp("lap_release_009", bcd(), 'h009);
      step(3);
      cmp("carry_010", bcd(), 'h010);

      step(356);
      cmp("reach_099", bcd(), 'h099);
      step(4);
      cmp("carry_100", bcd(), 'h100);

      step(3592);
      cmp("reach_998", bcd(), 'h998);
      step(4);
      cmp("sat_999", bcd(), 'h999);
      cmp("sat_full", int'(full), 1);
      cmp("sat_running", int'(running), 0);
      cmp("sat_tick", int'(tick), 1);
      for (int i = 0; i < 50; i++) begin
         go = ~go;
         step(1);
      end
      cmp("full_hold", bcd(), 'h999);
      cmp("full_no_tick", int'(tick), 0);
      go    = 1'b0;
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      cmp("clear_digits",  bcd(), 'h000);
      cmp("clear_full",    int'(full), 0);
      cmp("clear_running", int'(running), 0);
      step(3);
      cmp("idle_stays", bcd(), 'h000);

      go = 1'b1;
      step(9);
      cmp("rerun_002", bcd(), 'h002);
      lap = 1'b1;
      step(1);
      lap = 1'b0;
      step(8);
      cmp("lap_hold_002", bcd(), 'h002);
      clear = 1'b1;
      lap   = 1'b1;
      step(1);
      clear = 1'b0;
      lap   = 1'b0;
      cmp("clear_lap_digits",  bcd(), 'h000);
      cmp("clear_lap_running", int'(running), 0);
      step(5);
      cmp("clear_lap_unheld", bcd(), 'h001);

      step(2);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      cmp("midrun_reset_digits",  bcd(), 'h000);
      cmp("midrun_reset_running", int'(running), 0);
      cmp("midrun_reset_tick",    int'(tick), 0);
      step(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stopwatch_up.md
# stopwatch_up

Count-up elapsed-time stopwatch producing three BCD digits (000–999 s) for the existing seven-segment hex decoders. It is the counting-up counterpart to the 100 s countdown timer. It provides run/pause control, clear, lap-hold of the displayed value, saturation at 999, and a per-second tick pulse for downstream game logic. It contains its own one-second divider driven from the board clock.

## Interface
- TICKS_PER_SEC, 50000000, clock cycles per counted second. Minimum legal value is 2. Divider width is $clog2(TICKS_PER_SEC).
- CLOCK_50  in  1  system clock (50 MHz on board); the only clock.
- reset  in  1  synchronous, active-high reset.
- go  in  1  level: 1 = run, 0 = pause.
- clear  in  1  single-cycle pulse: zero the count, divider and lap hold; return to IDLE.
- lap  in  1  single-cycle pulse: toggle lap hold.
- hundreds  out  4  displayed BCD hundreds digit.
- tens  out  4  displayed BCD tens digit.
- ones  out  4  displayed BCD ones digit.
- running  out  1  high while state is RUN.
- full  out  1  high while state is FULL (count saturated at 999).
- tick  out  1  one-cycle pulse in the cycle the live count shows a new value.

## Operation
- Internal state: live count (3 BCD digits), divider d, FSM state, lap hold flag h, lap capture (3 BCD digits).
- FSM states: IDLE, RUN, PAUSE, FULL. Transitions are evaluated at each CLOCK_50 edge in the following priority order.
  - reset: everything goes to 0; state = IDLE.
  - clear: live count = 000, d = 0, h = 0, state = IDLE, from any state.
  - IDLE with go=1: go to RUN; d stays 0.
  - RUN with go=0: go to PAUSE. d and count hold; no increment on this edge, even if d == TICKS_PER_SEC-1.
  - RUN with go=1 and d < TICKS_PER_SEC-1: d <= d+1.
  - RUN with go=1 and d == TICKS_PER_SEC-1: d <= 0, count increments by 1 with BCD carry (9→0 ripples into the next digit), tick <= 1.
  - Increment producing 999: state <= FULL on the same edge.
  - PAUSE with go=1: go to RUN; d resumes from its held value, so the partial second is preserved.
  - FULL: count, d and state hold until clear or reset. go and tick are ignored; tick stays 0.
- BCD digits never hold values above 9. The count never wraps past 999.
- Lap hold:
  - A lap pulse with h=0 captures the live count into the lap capture and sets h=1.
  - A lap pulse with h=1 clears h.
  - Lap operates in every state.
  - clear and lap in the same cycle: clear wins, and h ends at 0.
- Display outputs:
  - h=0: hundreds/tens/ones = live count registers (no lag).
  - h=1: hundreds/tens/ones = lap capture; the live count keeps running underneath.
- running = (state == RUN). full = (state == FULL). Both are decoded from registered state.

## Timing
- Reset values: hundreds=tens=ones=0, running=0, full=0, tick=0; state IDLE, d=0, h=0.
- First increment: the edge that moves IDLE→RUN is edge 0. The count becomes 001 at edge TICKS_PER_SEC, then increments every TICKS_PER_SEC edges while go stays 1.
- tick is registered. It is high for exactly one cycle, and that cycle is the same cycle the incremented live count is first visible.
- tick is also asserted on the 998→999 increment. It is never asserted in IDLE, PAUSE or FULL.
- go is sampled every edge, so pause/resume latency is one cycle.
- After a pause at divider value d, resuming needs TICKS_PER_SEC-d RUN edges before the next increment.
- Lap toggle and clear take effect on the outputs one cycle after the pulse edge.
- Reset asserted mid-RUN: outputs read 000 and running=0 in the cycle after the reset edge.

## Test plan
All scenarios use TICKS_PER_SEC=4.
- Reset, then hold go=1 → running=1 after edge 1; ones=1 at edge 5, 2 at edge 9, 3 at edge 13; tick high only in those cycles.
- Run to 002, then drop go with d=2 for 20 cycles → count stays 002, running=0, no tick. Raise go → 003 after exactly 2 RUN edges.
- Run through 009→010 and 099→100 → BCD carry is correct; no digit ever exceeds 9.
- Run 3996 RUN edges → 999, full=1, running=0, tick seen on the final increment. Then toggle go and run 50 cycles → unchanged. Pulse clear → 000, full=0, state IDLE.
- At live 005, pulse lap → outputs hold 005 while the live count advances. At live 009, pulse lap → outputs show 009 the next cycle.
- With h=1, pulse clear and lap together → outputs 000, h=0. Assert reset mid-RUN → all outputs 0 the next cycle.
